eth_pkt_fifo: RTL and testbench

Single-clock, parametrised packet FIFO for the Ethernet datapath with checkpointing on both ports. Writes are speculative until committed and can be aborted back to the last commit. Reads are speculative until released and can be rewound to the last release, for retransmit. It sits between the MAC-side frame assembler and the packet parser/transmit scheduler wherever both run on one clock. Oversized frames are dropped automatically instead of being committed truncated.

---
 rtl/eth_pkt_fifo_pkg.sv | 14 +
 rtl/eth_sdp_ram.sv | 36 +++
 rtl/eth_pkt_fifo.sv | 126 ++++++++++++
 tb/tb_eth_pkt_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_fifo_pkg.sv
// Shared defaults and helpers for the Ethernet packet FIFO.
package eth_pkt_fifo_pkg;

    // 32 data bits plus 4 byte-enable/flag bits.
    localparam int unsigned ETH_FIFO_DATA_WIDTH = 36;
    // 2048-word default depth.
    localparam int unsigned ETH_FIFO_ADDR_WIDTH = 11;

    // Number of words addressed by an aw-bit RAM address.
    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: write port A, registered read port B, one clock.
module eth_sdp_ram
    import eth_pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ETH_FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = ETH_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:fifo_depth(ADDR_WIDTH)-1];

    // Write port A.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port B output register; holds its value between reads, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_pkt_fifo.sv
// Single-clock packet FIFO with write commit/abort and read release/rewind.
module eth_pkt_fifo
    import eth_pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ETH_FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = ETH_FIFO_ADDR_WIDTH,
    parameter bit          RD_REWIND  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] wr_d_in,
    input  logic                  wr_commit_in,
    input  logic                  wr_abort_in,
    output logic                  wr_full_out,
    output logic [ADDR_WIDTH:0]   wr_free_out,
    output logic                  wr_drop_out,
    input  logic                  rd_en_in,
    output logic [DATA_WIDTH-1:0] rd_d_out,
    output logic                  rd_valid_out,
    input  logic                  rd_release_in,
    input  logic                  rd_rewind_in,
    output logic                  rd_empty_out,
    output logic [ADDR_WIDTH:0]   rd_count_out
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(fifo_depth(ADDR_WIDTH));

    // Pointers carry a wrap bit above the RAM address.
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] head_chk_q, head_chk_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] tail_chk_q, tail_chk_d;
    logic          ovf_q, ovf_d;
    logic          drop_q, drop_d;
    logic          rd_valid_q;

    logic          wr_acc, rd_acc, ovf_now;
    logic [PW-1:0] head_inc, tail_inc;

    assign rd_count_out = head_chk_q - tail_q;
    assign wr_free_out  = DEPTH_P - (head_q - tail_chk_q);
    assign wr_full_out  = (wr_free_out == '0);
    assign rd_empty_out = (rd_count_out == '0);
    assign wr_drop_out  = drop_q;
    assign rd_valid_out = rd_valid_q;

    assign wr_acc   = wr_en_in & ~wr_full_out & ~wr_abort_in;
    assign rd_acc   = rd_en_in & ~rd_empty_out & ~rd_rewind_in;
    // A word lost this very cycle must already poison a same-cycle commit.
    assign ovf_now  = ovf_q | (wr_en_in & wr_full_out);
    assign head_inc = head_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
    assign tail_inc = tail_q + {{ADDR_WIDTH{1'b0}}, rd_acc};

    // Write-side next state: abort beats commit; an overflowed commit acts as an abort.
    always_comb begin
        head_d     = head_inc;
        head_chk_d = head_chk_q;
        ovf_d      = ovf_now;
        drop_d     = 1'b0;
        if (wr_abort_in) begin
            head_d = head_chk_q;
            ovf_d  = 1'b0;
        end else if (wr_commit_in) begin
            ovf_d = 1'b0;
            if (ovf_now) begin
                head_d = head_chk_q;
                drop_d = 1'b1;
            end else begin
                head_chk_d = head_inc;
            end
        end
    end

    // Read-side next state: rewind beats read and release.
    always_comb begin
        tail_d     = tail_inc;
        tail_chk_d = tail_chk_q;
        if (RD_REWIND) begin
            if (rd_rewind_in) begin
                tail_d = tail_chk_q;
            end else if (rd_release_in) begin
                tail_chk_d = tail_inc;
            end
        end else begin
            tail_chk_d = tail_inc;
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            head_chk_q <= '0;
            tail_q     <= '0;
            tail_chk_q <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            head_chk_q <= head_chk_d;
            tail_q     <= tail_d;
            tail_chk_q <= tail_chk_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_acc;
        end
    end

    eth_sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (head_q[ADDR_WIDTH-1:0]),
        .wr_data (wr_d_in),
        .rd_en   (rd_acc),
        .rd_addr (tail_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_d_out)
    );

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Scoreboard bench for eth_pkt_fifo against a queue-based frame model.
module tb_eth_pkt_fifo;

    localparam int DW    = 36;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en_in = 0, wr_commit_in = 0, wr_abort_in = 0;
    logic [DW-1:0] wr_d_in = '0;
    logic          wr_full_out, wr_drop_out;
    logic [AW:0]   wr_free_out, rd_count_out;
    logic          rd_en_in = 0, rd_release_in = 0, rd_rewind_in = 0;
    logic [DW-1:0] rd_d_out;
    logic          rd_valid_out, rd_empty_out;

    int checks = 0;
    int errors = 0;

    // Model: uncommitted, committed-unread, read-unreleased words; expected read data.
    logic [DW-1:0] pend[$];
    logic [DW-1:0] rdy[$];
    logic [DW-1:0] unrel[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf  = 0;
    bit            m_drop = 0;
    logic [DW-1:0] seq    = '0;

    eth_pkt_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_REWIND (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en_in     (wr_en_in),
        .wr_d_in      (wr_d_in),
        .wr_commit_in (wr_commit_in),
        .wr_abort_in  (wr_abort_in),
        .wr_full_out  (wr_full_out),
        .wr_free_out  (wr_free_out),
        .wr_drop_out  (wr_drop_out),
        .rd_en_in     (rd_en_in),
        .rd_d_out     (rd_d_out),
        .rd_valid_out (rd_valid_out),
        .rd_release_in(rd_release_in),
        .rd_rewind_in (rd_rewind_in),
        .rd_empty_out (rd_empty_out),
        .rd_count_out (rd_count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int m_free();
        return DEPTH - (pend.size() + rdy.size() + unrel.size());
    endfunction

    task automatic chk_status();
        chk("wr_free", 64'(wr_free_out), 64'(m_free()));
        chk("wr_full", 64'(wr_full_out), 64'(m_free() == 0));
        chk("rd_count", 64'(rd_count_out), 64'(rdy.size()));
        chk("rd_empty", 64'(rd_empty_out), 64'(rdy.size() == 0));
        chk("wr_drop", 64'(wr_drop_out), 64'(m_drop));
    endtask

    // One clock: drive inputs, advance the model, then compare status after the edge.
    task automatic step(input bit we, input logic [DW-1:0] wd, input bit cm, input bit ab,
                        input bit re, input bit rl, input bit rw);
        bit full, empty, wacc, racc, ovf_now;
        logic [DW-1:0] w;
        wr_en_in = we; wr_d_in = wd; wr_commit_in = cm; wr_abort_in = ab;
        rd_en_in = re; rd_release_in = rl; rd_rewind_in = rw;
        full    = (m_free() == 0);
        empty   = (rdy.size() == 0);
        wacc    = we && !full && !ab;
        racc    = re && !empty && !rw;
        ovf_now = m_ovf || (we && full);
        if (racc) begin
            w = rdy.pop_front();
            unrel.push_back(w);
            exp_q.push_back(w);
        end
        if (rw) begin
            while (unrel.size() > 0) rdy.push_front(unrel.pop_back());
        end else if (rl) begin
            unrel.delete();
        end
        m_drop = 0;
        if (ab) begin
            pend.delete();
            m_ovf = 0;
        end else if (cm && ovf_now) begin
            pend.delete();
            m_ovf  = 0;
            m_drop = 1;
        end else begin
            if (wacc) pend.push_back(wd);
            if (cm) begin
                foreach (pend[i]) rdy.push_back(pend[i]);
                pend.delete();
            end
            m_ovf = ovf_now;
        end
        @(posedge clk);
        #1;
        chk_status();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, 0);
    endtask

    // Read everything committed, then release it.
    task automatic drain();
        while (rdy.size() > 0) step(0, '0, 0, 0, 1, 0, 0);
        step(0, '0, 0, 0, 0, 1, 0);
    endtask

    // Monitor: every valid read must match the oldest expected word.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && rd_valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", 64'(rd_valid_out), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 64'(rd_d_out), 64'(e));
                end
            end
        end
    end

    initial begin
        logic [63:0] r;
        // Reset state.
        #2;
        chk("rst_full", 64'(wr_full_out), 64'd0);
        chk("rst_free", 64'(wr_free_out), 64'(DEPTH));
        chk("rst_drop", 64'(wr_drop_out), 64'd0);
        chk("rst_empty", 64'(rd_empty_out), 64'd1);
        chk("rst_count", 64'(rd_count_out), 64'd0);
        chk("rst_valid", 64'(rd_valid_out), 64'd0);
        chk("rst_rd_d", 64'(rd_d_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Five words committed on the last, then read back.
        for (int i = 1; i <= 5; i++) step(1, DW'(i), i == 5, 0, 0, 0, 0);
        chk("commit5_count", 64'(rd_count_out), 64'd5);
        drain();

        // Abort three words, commit two.
        for (int i = 0; i < 3; i++) step(1, DW'(32'h100 + i), 0, 0, 0, 0, 0);
        step(0, '0, 0, 1, 0, 0, 0);
        step(1, DW'(32'h200), 0, 0, 0, 0, 0);
        step(1, DW'(32'h201), 1, 0, 0, 0, 0);
        chk("abort_free", 64'(wr_free_out), 64'(DEPTH - 2));
        drain();

        // Oversized frame is dropped.
        for (int i = 0; i <= DEPTH; i++) step(1, DW'(32'h300 + i), i == DEPTH, 0, 0, 0, 0);
        chk("drop_pulse", 64'(wr_drop_out), 64'd1);
        idle(1);
        chk("drop_free", 64'(wr_free_out), 64'(DEPTH));

        // Read three, rewind, read four.
        for (int i = 1; i <= 4; i++) step(1, DW'(i), i == 4, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1, 0, 0);
        step(0, '0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, '0, 0, 0, 1, 0, 0);
        chk("rewind_free", 64'(wr_free_out), 64'(DEPTH - 4));
        step(0, '0, 0, 0, 0, 1, 0);

        // Fill, release one while writing (rejected), then stream across several wraps.
        for (int i = 0; i < DEPTH; i++) begin
            seq++;
            step(1, seq, i == DEPTH - 1, 0, 0, 0, 0);
        end
        seq++;
        step(1, seq, 1, 0, 1, 1, 0);
        chk("full_reject_count", 64'(rd_count_out), 64'(DEPTH - 1));
        for (int i = 0; i < 7 * DEPTH; i++) begin
            seq++;
            step(1, seq, 1, 0, 1, 1, 0);
        end
        drain();

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            r = {$urandom, $urandom};
            step($urandom_range(0, 99) < 60, DW'(r), $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3);
        end
        drain();

        // Asynchronous reset mid-frame with committed data present.
        for (int i = 0; i < 3; i++) step(1, DW'(32'h400 + i), i == 2, 0, 0, 0, 0);
        step(0, '0, 0, 0, 1, 0, 0);
        step(1, DW'(32'h500), 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_full", 64'(wr_full_out), 64'd0);
        chk("arst_free", 64'(wr_free_out), 64'(DEPTH));
        chk("arst_empty", 64'(rd_empty_out), 64'd1);
        chk("arst_count", 64'(rd_count_out), 64'd0);
        chk("arst_valid", 64'(rd_valid_out), 64'd0);
        chk("arst_rd_d", 64'(rd_d_out), 64'd0);
        pend.delete(); rdy.delete(); unrel.delete(); exp_q.delete();
        m_ovf = 0; m_drop = 0;
        wr_en_in = 0; wr_commit_in = 0; rd_en_in = 0; rd_release_in = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1, DW'(32'h600), 1, 0, 0, 0, 0);
        drain();
        idle(2);
        chk("exp_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
